// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling from a
// half-bit start qualification, registered byte/strobe outputs.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       new_data,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_reg, state_next;
  logic        rx_meta_reg, rx_sync_reg;
  logic [15:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic        new_data_reg, new_data_next;
  logic        frame_err_reg, frame_err_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      state_reg     <= IDLE;
      clk_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_out_reg  <= '0;
      new_data_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_meta_reg   <= rx;
      rx_sync_reg   <= rx_meta_reg;
      state_reg     <= state_next;
      clk_cnt_reg   <= clk_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      data_out_reg  <= data_out_next;
      new_data_reg  <= new_data_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clk_cnt_next   = clk_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    data_out_next  = data_out_reg;
    new_data_next  = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_sync_reg) begin
          state_next   = START;
          clk_cnt_next = '0;
        end
      end
      START: begin
        // A line back high at mid start bit is treated as a glitch.
        if (clk_cnt_reg == HALF_LAST) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = rx_sync_reg ? IDLE : DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_reg == BIT_LAST) begin
          shift_next[bit_idx_reg] = rx_sync_reg;
          clk_cnt_next            = '0;
          bit_idx_next            = 3'(bit_idx_reg + 3'd1);
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt_reg == BIT_LAST) begin
          clk_cnt_next = '0;
          if (rx_sync_reg) begin
            data_out_next = shift_reg;
            new_data_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 16'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot be mistaken for new frames.
        if (rx_sync_reg) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data_out  = data_out_reg;
  assign new_data  = new_data_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: lane 0 at 16 clocks/bit, lane 1 at 4,
// both checked every cycle against a sample-point model of the serial line.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int NL     = 2;
  localparam int MAXCYC = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rx_line [NL];
  logic       rst_n_l [NL];
  logic [7:0] dout    [NL];
  logic       nd      [NL];
  logic       fe      [NL];
  logic       bsy     [NL];

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      uart_rx #(.CLKS_PER_BIT(gi == 0 ? 16 : 4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n_l[gi]),
        .rx       (rx_line[gi]),
        .data_out (dout[gi]),
        .new_data (nd[gi]),
        .frame_err(fe[gi]),
        .busy     (bsy[gi])
      );
    end
  endgenerate

  function automatic int cpb(int l);
    return (l == 0) ? 16 : 4;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(string name, int l, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s lane%0d cyc%0d: got %0h expected %0h", name, l, cyc, act, exp);
  endtask

  // Reference model: s_hist[l][n] is the synchronized line level after edge n.
  // A frame detected at index d is judged purely by sample positions
  // d+H (start), d+H+(i+1)*C (data bit i) and d+H+9*C (stop).
  bit         s_hist   [NL][MAXCYC];
  int         phase    [NL];   // 0 idle, 1 in frame, 2 waiting for line high
  int         fstart   [NL];
  bit         meta_m   [NL];
  bit         sync_m   [NL];
  logic [7:0] exp_data [NL];
  bit         exp_nd   [NL];
  bit         exp_fe   [NL];
  bit         exp_busy [NL];
  bit         mvalid   [NL] = '{0, 0};

  initial begin
    int n, c, h, k;
    bit sv;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      n = cyc;
      if (n < MAXCYC) begin
        for (int l = 0; l < NL; l++) begin
          c = cpb(l);
          h = c / 2;
          if (!rst_n_l[l]) begin
            phase[l]    = 0;
            exp_data[l] = 8'h00;
            exp_nd[l]   = 1'b0;
            exp_fe[l]   = 1'b0;
            meta_m[l]   = 1'b1;
            sync_m[l]   = 1'b1;
            mvalid[l]   = 1'b1;
            s_hist[l][n] = 1'b1;
          end else begin
            sv        = sync_m[l];
            exp_nd[l] = 1'b0;
            exp_fe[l] = 1'b0;
            case (phase[l])
              0: if (!sv) begin
                fstart[l] = n - 1;
                phase[l]  = 1;
              end
              1: begin
                k = n - 1 - fstart[l];
                if (k == h && sv) begin
                  phase[l] = 0;
                end else if (k == h + 9 * c) begin
                  for (int i = 0; i < 8; i++) b[i] = s_hist[l][fstart[l] + h + (i + 1) * c];
                  if (sv) begin
                    exp_data[l] = b;
                    exp_nd[l]   = 1'b1;
                    phase[l]    = 0;
                  end else begin
                    exp_fe[l] = 1'b1;
                    phase[l]  = 2;
                  end
                end
              end
              default: if (sv) phase[l] = 0;
            endcase
            sync_m[l]    = meta_m[l];
            meta_m[l]    = rx_line[l];
            s_hist[l][n] = sync_m[l];
          end
          exp_busy[l] = (phase[l] != 0);
        end
      end
    end
  end

  // Compare process plus event monitor used by the directed literal checks.
  int         nd_cnt   [NL] = '{0, 0};
  int         fe_cnt   [NL] = '{0, 0};
  int         busy_cnt [NL] = '{0, 0};
  int         last_nd  [NL] = '{0, 0};
  int         prev_nd  [NL] = '{0, 0};
  logic [7:0] last_b   [NL];
  logic [7:0] prev_b   [NL];

  initial begin
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (mvalid[l]) begin
          check("data_out", l, 32'(dout[l]), 32'(exp_data[l]));
          check("new_data", l, 32'(nd[l]), 32'(exp_nd[l]));
          check("frame_err", l, 32'(fe[l]), 32'(exp_fe[l]));
          check("busy", l, 32'(bsy[l]), 32'(exp_busy[l]));
        end
        if (nd[l] === 1'b1) begin
          nd_cnt[l]++;
          prev_nd[l] = last_nd[l];
          last_nd[l] = cyc;
          prev_b[l]  = last_b[l];
          last_b[l]  = dout[l];
        end
        if (fe[l] === 1'b1) fe_cnt[l]++;
        if (bsy[l] === 1'b1) busy_cnt[l]++;
      end
    end
  end

  // Hold rx_line[l] at v for n cycles starting at the next falling edge.
  task automatic drive_bit(int l, bit v, int n, output int t);
    @(negedge clk);
    rx_line[l] = v;
    t = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(int l, logic [7:0] b, bit stopv, output int t0);
    int c, t;
    c = cpb(l);
    drive_bit(l, 1'b0, c, t0);
    for (int i = 0; i < 8; i++) drive_bit(l, b[i], c, t);
    drive_bit(l, stopv, c, t);
  endtask

  task automatic random_frames(int l, int nf);
    int t, c;
    c = cpb(l);
    for (int f = 0; f < nf; f++) begin
      send_frame(l, 8'($urandom), ($urandom_range(0, 4) != 0), t);
      if ($urandom_range(0, 5) == 0) begin
        drive_bit(l, 1'b0, $urandom_range(1, c - 1), t);
        drive_bit(l, 1'b1, 2 * c, t);
      end
      if ($urandom_range(0, 2) != 0) drive_bit(l, 1'b1, $urandom_range(1, 12), t);
    end
    drive_bit(l, 1'b1, 12 * c, t);
  endtask

  initial begin
    int t0, t, c, b0;
    for (int l = 0; l < NL; l++) begin
      rx_line[l] = 1'b1;
      rst_n_l[l] = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("reset data_out", 0, 32'(dout[0]), 32'h00);
    check("reset busy", 0, 32'(bsy[0]), 32'h0);
    for (int l = 0; l < NL; l++) rst_n_l[l] = 1'b1;
    c = cpb(0);
    drive_bit(0, 1'b1, 20, t);

    // Good frame: strobe lands 2 sync + 1 detect + H + 9C cycles after start edge.
    send_frame(0, 8'h55, 1'b1, t0);
    drive_bit(0, 1'b1, c, t);
    check("0x55 data", 0, 32'(dout[0]), 32'h55);
    check("0x55 latency", 0, 32'(last_nd[0] - t0), 32'd155);
    check("0x55 nd count", 0, 32'(nd_cnt[0]), 32'd1);
    check("0x55 fe count", 0, 32'(fe_cnt[0]), 32'd0);

    send_frame(0, 8'hA3, 1'b1, t);
    send_frame(0, 8'h0F, 1'b1, t);
    drive_bit(0, 1'b1, c, t);
    check("b2b first byte", 0, 32'(prev_b[0]), 32'hA3);
    check("b2b second byte", 0, 32'(last_b[0]), 32'h0F);
    check("b2b pulse gap", 0, 32'(last_nd[0] - prev_nd[0]), 32'd160);
    check("b2b nd count", 0, 32'(nd_cnt[0]), 32'd3);

    b0 = busy_cnt[0];
    drive_bit(0, 1'b0, 4, t);
    drive_bit(0, 1'b1, 30, t);
    check("glitch busy cycles", 0, 32'(busy_cnt[0] - b0), 32'd8);
    check("glitch nd count", 0, 32'(nd_cnt[0]), 32'd3);
    check("glitch fe count", 0, 32'(fe_cnt[0]), 32'd0);
    check("glitch data", 0, 32'(dout[0]), 32'h0F);

    send_frame(0, 8'h55, 1'b1, t);
    drive_bit(0, 1'b1, c, t);
    check("resend 0x55 data", 0, 32'(dout[0]), 32'h55);
    send_frame(0, 8'h3C, 1'b0, t);
    drive_bit(0, 1'b0, 100, t);
    check("bad stop fe count", 0, 32'(fe_cnt[0]), 32'd1);
    check("bad stop nd count", 0, 32'(nd_cnt[0]), 32'd4);
    check("bad stop data", 0, 32'(dout[0]), 32'h55);
    check("break busy", 0, 32'(bsy[0]), 32'h1);
    drive_bit(0, 1'b1, 20, t);
    check("break released busy", 0, 32'(bsy[0]), 32'h0);
    send_frame(0, 8'h81, 1'b1, t);
    drive_bit(0, 1'b1, c, t);
    check("0x81 data", 0, 32'(dout[0]), 32'h81);
    check("0x81 nd count", 0, 32'(nd_cnt[0]), 32'd5);

    // Abort a frame with reset in the middle of data bit 4.
    drive_bit(0, 1'b0, c, t);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0, c, t);
    drive_bit(0, 1'b1, c / 2, t);
    @(negedge clk);
    rst_n_l[0] = 1'b0;
    rx_line[0] = 1'b1;
    @(negedge clk);
    check("abort data_out", 0, 32'(dout[0]), 32'h00);
    check("abort busy", 0, 32'(bsy[0]), 32'h0);
    check("abort new_data", 0, 32'(nd[0]), 32'h0);
    rst_n_l[0] = 1'b1;
    drive_bit(0, 1'b1, 3 * c, t);
    check("abort nd count", 0, 32'(nd_cnt[0]), 32'd5);
    send_frame(0, 8'hFF, 1'b1, t);
    drive_bit(0, 1'b1, c, t);
    check("post-abort 0xFF", 0, 32'(dout[0]), 32'hFF);
    check("post-abort nd count", 0, 32'(nd_cnt[0]), 32'd6);

    random_frames(0, 25);

    // Minimum bit period lane.
    drive_bit(1, 1'b1, 10, t);
    send_frame(1, 8'h00, 1'b1, t);
    drive_bit(1, 1'b1, 8, t);
    check("cpb4 0x00 data", 1, 32'(dout[1]), 32'h00);
    check("cpb4 0x00 nd count", 1, 32'(nd_cnt[1]), 32'd1);
    send_frame(1, 8'hFF, 1'b1, t);
    drive_bit(1, 1'b1, 8, t);
    check("cpb4 0xFF data", 1, 32'(dout[1]), 32'hFF);
    check("cpb4 0xFF nd count", 1, 32'(nd_cnt[1]), 32'd2);
    random_frames(1, 20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud); legal range is 4 to 65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-005 The block SHALL have port data_out, output, 8 bits: the last correctly framed byte received; it feeds the memory's in_uart input.
REQ-006 The block SHALL have port new_data, output, 1 bit: a one-cycle strobe that data_out has just been updated; it feeds the memory's uart_new_data input.
REQ-007 The block SHALL have port frame_err, output, 1 bit: a one-cycle strobe that a stop bit was sampled low.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is in progress (any state other than IDLE).

Function
REQ-009 The block SHALL pass rx through a 2-flop synchronizer (rx_sync); all decisions SHALL use rx_sync only.
REQ-010 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-011 The block SHALL implement states IDLE, START, DATA, STOP and BREAK, with a cycle counter clk_cnt (16 bits) and a bit index bit_idx (3 bits).
REQ-012 In IDLE, rx_sync==0 SHALL cause a transition to START with clk_cnt=0.
REQ-013 In START, when clk_cnt reaches CLKS_PER_BIT/2-1 (integer division), rx_sync SHALL be sampled: 0 goes to DATA with clk_cnt=0 and bit_idx=0; 1 (glitch) goes to IDLE with no output activity.
REQ-014 In DATA, when clk_cnt reaches CLKS_PER_BIT-1, rx_sync SHALL be shifted into the shift register at position bit_idx and clk_cnt cleared.
REQ-015 In DATA, bit_idx SHALL increment after each sample; after the sample with bit_idx==7 the block SHALL go to STOP.
REQ-016 In STOP, when clk_cnt reaches CLKS_PER_BIT-1, rx_sync SHALL be sampled.
REQ-017 A STOP sample of 1 SHALL load data_out from the shift register, pulse new_data for exactly one cycle (the next cycle), and go to IDLE.
REQ-018 A STOP sample of 0 SHALL pulse frame_err for one cycle, leave data_out and new_data unchanged, and go to BREAK.
REQ-019 BREAK SHALL stay until rx_sync==1, then go to IDLE; a line held low SHALL NOT generate further frames.
REQ-020 new_data and frame_err SHALL never be high in the same cycle, and each SHALL be low in every cycle not named above.
REQ-021 data_out SHALL hold its value between strobes indefinitely; the downstream memory captures it on the rising edge of new_data.
REQ-022 A start edge arriving in the cycle the block returns to IDLE SHALL be detected on the following cycle, so back-to-back frames lose no bytes.
REQ-023 rx activity during START, DATA or STOP outside the sample points SHALL be ignored; there is no oversampling or majority vote.

Reset
REQ-024 While rst_n==0 at a clk edge, the block SHALL set state=IDLE, clk_cnt=0, bit_idx=0, shift register=0x00, data_out=0x00, new_data=0, frame_err=0, busy=0, and both synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-026 After reset release, the first start bit SHALL be recognised only once rx_sync has been observed at 0 starting from IDLE.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-027 Send 0x55 with a good stop bit -> data_out=0x55 and new_data high for exactly 1 cycle, about 9.5 bit times plus 2 sync cycles after the start edge; frame_err stays 0.
REQ-028 Send 0xA3 then 0x0F back-to-back with no idle gap -> two new_data pulses about 160 cycles apart, with data_out=0xA3 then data_out=0x0F.
REQ-029 Drive a 4-cycle low glitch on idle rx -> busy returns to 0 after about 8 cycles; no new_data, no frame_err, data_out unchanged.
REQ-030 Send 0x3C with stop bit=0 while data_out=0x55 -> one frame_err pulse, no new_data, data_out stays 0x55; hold rx low for 100 cycles -> no further strobes; release rx and send 0x81 -> data_out=0x81.
REQ-031 Assert rst_n=0 during data bit 4 of a frame -> all outputs 0 on the next cycle with no strobe; the following clean frame 0xFF is received correctly.
REQ-032 With CLKS_PER_BIT=4, send 0x00 and 0xFF -> both bytes are received correctly (minimum-parameter corner).
